// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bram_pkg
// Purpose : Shared definitions for the parametrised dual-port block RAM.
//           Read-during-write mode encodings, a constant-evaluable clog2
//           used to derive address widths, and a lane-merge helper that
//           combines an old word with a new word under a per-lane mask.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package bram_pkg;

    // Same-address read-during-write result selection
    localparam int RDW_READ_FIRST  = 0;   // read returns the word before the write
    localparam int RDW_WRITE_FIRST = 1;   // read returns the word after the write

    // The merge helper works on a fixed maximum width so that it can be shared
    // by every instance; callers zero-extend on the way in and truncate on the
    // way out, which folds away at elaboration.
    localparam int MERGE_MAX_W      = 1024;
    localparam int MERGE_MAX_LANES  = 1024;
    localparam int MERGE_LANE_IDX_W = 10;

    // Ceiling log2, never less than 1 so that a one-word memory still has a
    // legal (single-bit) address port.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    // Returns old_word with every lane whose mask bit is set replaced by the
    // corresponding lane of new_word. lane_w is the number of bits per lane.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0]     old_word,
        input logic [MERGE_MAX_W-1:0]     new_word,
        input logic [MERGE_MAX_LANES-1:0] lane_mask,
        input int                         lane_w
    );
        logic [MERGE_MAX_W-1:0]      merged;
        logic [MERGE_LANE_IDX_W-1:0] lane;
        merged = old_word;
        for (int i = 0; i < MERGE_MAX_W; i++) begin
            lane = MERGE_LANE_IDX_W'(i / lane_w);
            if (lane_mask[lane]) begin
                merged[i] = new_word[i];
            end
        end
        return merged;
    endfunction

endpackage : bram_pkg
`default_nettype wire

// File: rtl/bram_out_stage.sv
`default_nettype none
// ============================================================================
// Module  : bram_out_stage
// Purpose : Optional output pipeline register for one RAM read port.
//           Data and valid move together; the data register only loads when
//           a new read result arrives, so the port holds its last value
//           while idle.
// Ports   : clk      - clock, rising edge
//           reset_n  - asynchronous active-low reset (clears data and valid)
//           i_valid  - incoming read result is new this cycle
//           i_data   - incoming read data
//           o_valid  - registered valid
//           o_data   - registered data
// Revision: 1.0 - initial release
// ============================================================================
module bram_out_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : bram_out_stage
`default_nettype wire

// File: rtl/bram_dp_param.sv
`default_nettype none
// ============================================================================
// Module  : bram_dp_param
// Purpose : Parametrised simple-dual-port block RAM with synchronous reads.
//           Port A reads and writes (byte-lane write enables); port B is
//           read-only. Both ports share the same read-during-write policy,
//           an optional output register and per-port read-valid strobes.
// Ports   : clk      - sole clock, rising edge
//           reset_n  - asynchronous active-low reset of the read path
//           a_en     - port A access enable (every access is also a read)
//           a_we     - port A per-lane write enable, qualified by a_en
//           a_addr   - port A address
//           a_din    - port A write data
//           a_dout   - port A read data
//           a_valid  - a_dout carries a new read result this cycle
//           b_en     - port B read enable
//           b_addr   - port B address
//           b_dout   - port B read data
//           b_valid  - b_dout carries a new read result this cycle
// Notes   : WIDTH must be a multiple of LANE_W. Memory contents are never
//           reset. Addresses at or beyond DEPTH drop writes and read as 0.
// Revision: 1.0 - initial release
// ============================================================================
module bram_dp_param
    import bram_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 2048,
    parameter  int LANE_W   = 8,
    parameter  int OUT_REG  = 0,
    parameter  int RDW_MODE = RDW_READ_FIRST,
    localparam int ADDR_W   = clog2(DEPTH),
    localparam int NLANES   = WIDTH / LANE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_en,
    input  logic [NLANES-1:0] a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_din,
    output logic [WIDTH-1:0]  a_dout,
    output logic              a_valid,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [WIDTH-1:0]  b_dout,
    output logic              b_valid
);

    // One extra bit so the range compare also works when DEPTH is an exact
    // power of two (then every address is in range and the compare folds).
    localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    // ------------------------------------------------------------------------
    // Address qualification
    // ------------------------------------------------------------------------
    logic w_a_in_range;
    logic w_b_in_range;
    logic w_b_collide;

    assign w_a_in_range = ({1'b0, a_addr} < c_depth_ext);
    assign w_b_in_range = ({1'b0, b_addr} < c_depth_ext);

    // Port B sees a same-cycle write only when that write actually lands
    assign w_b_collide  = a_en && w_a_in_range && (a_addr == b_addr);

    // ------------------------------------------------------------------------
    // Lane merge, sized for this instance
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] merge_word(
        input logic [WIDTH-1:0]  old_word,
        input logic [WIDTH-1:0]  new_word,
        input logic [NLANES-1:0] lane_mask
    );
        return WIDTH'(lane_merge(MERGE_MAX_W'(old_word),
                                 MERGE_MAX_W'(new_word),
                                 MERGE_MAX_LANES'(lane_mask),
                                 LANE_W));
    endfunction

    // ------------------------------------------------------------------------
    // Write port: per-lane enables so synthesis maps onto byte-write BRAM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (a_en && w_a_in_range) begin
            for (int i = 0; i < NLANES; i++) begin
                if (a_we[i]) begin
                    r_mem[a_addr][i*LANE_W +: LANE_W] <= a_din[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read data selection (value to be captured at the next edge)
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_a_old;
    logic [WIDTH-1:0] w_b_old;
    logic [WIDTH-1:0] w_a_rd_next;
    logic [WIDTH-1:0] w_b_rd_next;

    assign w_a_old = r_mem[a_addr];
    assign w_b_old = r_mem[b_addr];

    always_comb begin
        w_a_rd_next = '0;
        if (w_a_in_range) begin
            if (RDW_MODE == RDW_WRITE_FIRST) begin
                // Written lanes show a_din, untouched lanes show storage
                w_a_rd_next = merge_word(w_a_old, a_din, a_we);
            end else begin
                w_a_rd_next = w_a_old;
            end
        end
    end

    always_comb begin
        w_b_rd_next = '0;
        if (w_b_in_range) begin
            if ((RDW_MODE == RDW_WRITE_FIRST) && w_b_collide) begin
                w_b_rd_next = merge_word(w_b_old, a_din, a_we);
            end else begin
                w_b_rd_next = w_b_old;
            end
        end
    end

    // ------------------------------------------------------------------------
    // First read register stage. Data loads only on an enabled read so the
    // port holds its last result while idle; valid pulses for one cycle.
    // ------------------------------------------------------------------------
    logic             r_a_rd_valid;
    logic [WIDTH-1:0] r_a_rd_data;
    logic             r_b_rd_valid;
    logic [WIDTH-1:0] r_b_rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_rd_valid <= 1'b0;
            r_a_rd_data  <= '0;
            r_b_rd_valid <= 1'b0;
            r_b_rd_data  <= '0;
        end else begin
            r_a_rd_valid <= a_en;
            r_b_rd_valid <= b_en;
            if (a_en) begin
                r_a_rd_data <= w_a_rd_next;
            end
            if (b_en) begin
                r_b_rd_data <= w_b_rd_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional output register, one per port
    // ------------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        bram_out_stage #(
            .WIDTH   (WIDTH)
        ) u_a_out_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .i_valid (r_a_rd_valid),
            .i_data  (r_a_rd_data),
            .o_valid (a_valid),
            .o_data  (a_dout)
        );

        bram_out_stage #(
            .WIDTH   (WIDTH)
        ) u_b_out_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .i_valid (r_b_rd_valid),
            .i_data  (r_b_rd_data),
            .o_valid (b_valid),
            .o_data  (b_dout)
        );
    end else begin : g_no_out_reg
        assign a_valid = r_a_rd_valid;
        assign a_dout  = r_a_rd_data;
        assign b_valid = r_b_rd_valid;
        assign b_dout  = r_b_rd_data;
    end

    // ------------------------------------------------------------------------
    // Simulation-only guard against writes with unknown control
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset_n === 1'b1) begin
            if ($isunknown(a_en) ||
                ((a_en === 1'b1) && (a_we != '0) && $isunknown(a_addr))) begin
                $error("bram_dp_param: port A write with unknown enable or address");
            end
        end
    end
`endif

endmodule : bram_dp_param
`default_nettype wire

// File: tb/tb_bram_dp_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_dp_param
// Purpose : Self-checking bench for bram_dp_param. Two 32-bit, 4-lane
//           instances share the stimulus:
//             dut0 : DEPTH=2048, OUT_REG=0, read-first
//             dut1 : DEPTH=1000, OUT_REG=1, write-first
//           dut1 sees the low 10 bits of each address, so 1000..1023 are
//           out of range for it. A word-level reference model (arrays plus
//           per-port result queues) predicts every output.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bram_dp_param;

    logic        clk;
    logic        reset_n;
    logic        a_en;
    logic [3:0]  a_we;
    logic [31:0] a_din;
    logic        b_en;
    logic [10:0] a_addr0;
    logic [10:0] b_addr0;
    logic [9:0]  a_addr1;
    logic [9:0]  b_addr1;

    logic [31:0] a_dout0;
    logic        a_valid0;
    logic [31:0] b_dout0;
    logic        b_valid0;
    logic [31:0] a_dout1;
    logic        a_valid1;
    logic [31:0] b_dout1;
    logic        b_valid1;

    bram_dp_param #(
        .WIDTH    (32),
        .DEPTH    (2048),
        .LANE_W   (8),
        .OUT_REG  (0),
        .RDW_MODE (0)
    ) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .a_en    (a_en),
        .a_we    (a_we),
        .a_addr  (a_addr0),
        .a_din   (a_din),
        .a_dout  (a_dout0),
        .a_valid (a_valid0),
        .b_en    (b_en),
        .b_addr  (b_addr0),
        .b_dout  (b_dout0),
        .b_valid (b_valid0)
    );

    bram_dp_param #(
        .WIDTH    (32),
        .DEPTH    (1000),
        .LANE_W   (8),
        .OUT_REG  (1),
        .RDW_MODE (1)
    ) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .a_en    (a_en),
        .a_we    (a_we),
        .a_addr  (a_addr1),
        .a_din   (a_din),
        .a_dout  (a_dout1),
        .a_valid (a_valid1),
        .b_en    (b_en),
        .b_addr  (b_addr1),
        .b_dout  (b_dout1),
        .b_valid (b_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        bit          v;   // read issued
        bit          k;   // data is known (location was fully written before)
        logic [31:0] d;
    } res_t;

    logic [31:0] mem0   [2048];
    bit          known0 [2048];
    logic [31:0] mem1   [1000];
    bit          known1 [1000];

    res_t        pipe  [4][$];   // index: 0 dut0.a, 1 dut0.b, 2 dut1.a, 3 dut1.b
    bit          exp_v [4];
    bit          exp_k [4];
    logic [31:0] exp_d [4];

    string names [4] = '{"dut0_a", "dut0_b", "dut1_a", "dut1_b"};

    int n_assert;
    int n_fail;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  we);
        logic [31:0] m;
        m = old_w;
        for (int l = 0; l < 4; l++) begin
            if (we[l]) m[l*8 +: 8] = new_w[l*8 +: 8];
        end
        return m;
    endfunction

    function automatic logic [31:0] mget(input int d, input int addr);
        if (d == 0) return mem0[addr];
        return mem1[addr];
    endfunction

    function automatic bit kget(input int d, input int addr);
        if (d == 0) return known0[addr];
        return known1[addr];
    endfunction

    task automatic model_reset();
        res_t idle;
        idle.v = 1'b0;
        idle.k = 1'b1;
        idle.d = '0;
        for (int p = 0; p < 4; p++) begin
            pipe[p].delete();
            // the registered-output instance has one extra stage in flight
            if (p >= 2) pipe[p].push_back(idle);
            exp_v[p] = 1'b0;
            exp_k[p] = 1'b1;
            exp_d[p] = '0;
        end
    endtask

    // Called right after each rising edge with the inputs sampled at it
    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            int          aa;
            int          ba;
            int          dep;
            bit          wf;
            res_t        ra;
            res_t        rb;
            logic [31:0] merged;
            aa  = (d == 0) ? int'(a_addr0) : int'(a_addr1);
            ba  = (d == 0) ? int'(b_addr0) : int'(b_addr1);
            dep = (d == 0) ? 2048 : 1000;
            wf  = (d == 1);
            ra.v = a_en;
            rb.v = b_en;
            if (aa >= dep) begin
                ra.k = 1'b1;
                ra.d = '0;
            end else begin
                ra.k = kget(d, aa);
                ra.d = wf ? merge_lanes(mget(d, aa), a_din, a_we) : mget(d, aa);
            end
            if (ba >= dep) begin
                rb.k = 1'b1;
                rb.d = '0;
            end else begin
                rb.k = kget(d, ba);
                if (wf && a_en && (aa == ba)) rb.d = merge_lanes(mget(d, ba), a_din, a_we);
                else                          rb.d = mget(d, ba);
            end
            pipe[2*d].push_back(ra);
            pipe[2*d+1].push_back(rb);
            if (a_en && (aa < dep)) begin
                merged = merge_lanes(mget(d, aa), a_din, a_we);
                if (d == 0) begin
                    mem0[aa] = merged;
                    if (a_we == 4'hF) known0[aa] = 1'b1;
                end else begin
                    mem1[aa] = merged;
                    if (a_we == 4'hF) known1[aa] = 1'b1;
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            res_t o;
            o = pipe[p].pop_front();
            exp_v[p] = o.v;
            if (o.v) begin
                exp_d[p] = o.d;
                exp_k[p] = o.k;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    function automatic logic [31:0] obs_d(input int p);
        case (p)
            0:       return a_dout0;
            1:       return b_dout0;
            2:       return a_dout1;
            default: return b_dout1;
        endcase
    endfunction

    function automatic logic obs_v(input int p);
        case (p)
            0:       return a_valid0;
            1:       return b_valid0;
            2:       return a_valid1;
            default: return b_valid1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int p = 0; p < 4; p++) begin
            chk({names[p], "_valid"}, 32'(obs_v(p)), 32'(exp_v[p]));
            if (exp_k[p]) chk({names[p], "_dout"}, obs_d(p), exp_d[p]);
        end
    endtask

    task automatic drive(input bit ae, input logic [3:0] we, input logic [31:0] din,
                         input int aaddr, input bit be, input int baddr);
        a_en    = ae;
        a_we    = we;
        a_din   = din;
        a_addr0 = 11'(aaddr);
        a_addr1 = 10'(aaddr);
        b_en    = be;
        b_addr0 = 11'(baddr);
        b_addr1 = 10'(baddr);
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 0, 1'b0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 15));
            1:       return int'($urandom_range(995, 1010));
            default: return int'($urandom_range(2040, 2047));
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b1;
        idle();
        model_reset();

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) step();
        reset_n = 1'b1;
        step();

        // Preload every location the test touches with full-word writes
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'hF, 32'($urandom), a, 1'b0, 0);
            step();
        end
        for (int a = 995; a <= 1010; a++) begin
            drive(1'b1, 4'hF, 32'($urandom), a, 1'b0, 0);
            step();
        end
        for (int a = 2040; a <= 2047; a++) begin
            drive(1'b1, 4'hF, 32'($urandom), a, 1'b0, 0);
            step();
        end

        // Basic write/read at the top address, one-cycle latency
        drive(1'b1, 4'hF, 32'hA5, 'h7FF, 1'b0, 0);
        step();
        drive(1'b0, 4'h0, 32'h0, 0, 1'b1, 'h7FF);
        step();
        chk("basic_b0_dout", b_dout0, 32'hA5);
        chk("basic_b0_valid", 32'(b_valid0), 32'd1);

        // Two-cycle latency with the output register
        drive(1'b1, 4'hF, 32'hA5, 999, 1'b0, 0);
        step();
        drive(1'b0, 4'h0, 32'h0, 0, 1'b1, 999);
        step();
        chk("lat2_b1_valid_early", 32'(b_valid1), 32'd0);
        idle();
        step();
        chk("lat2_b1_dout", b_dout1, 32'hA5);
        chk("lat2_b1_valid", 32'(b_valid1), 32'd1);

        // Byte lanes
        drive(1'b1, 4'hF, 32'h11223344, 5, 1'b0, 0);
        step();
        drive(1'b1, 4'b0101, 32'hAABBCCDD, 5, 1'b0, 0);
        step();
        drive(1'b0, 4'h0, 32'h0, 0, 1'b1, 5);
        step();
        chk("lanes_b0_dout", b_dout0, 32'h11BB33DD);
        idle();
        step();
        chk("lanes_b1_dout", b_dout1, 32'h11BB33DD);

        // Read during write, same address on both ports
        drive(1'b1, 4'hF, 32'h11, 7, 1'b0, 0);
        step();
        drive(1'b1, 4'hF, 32'h22, 7, 1'b1, 7);
        step();
        chk("rdw_a0_old", a_dout0, 32'h11);
        chk("rdw_b0_old", b_dout0, 32'h11);
        idle();
        step();
        chk("rdw_a1_new", a_dout1, 32'h22);
        chk("rdw_b1_new", b_dout1, 32'h22);

        // Streaming reads with no bubbles, then hold
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'hF, 32'(i * 3), i, 1'b0, 0);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'h0, 32'h0, 0, 1'b1, i);
            step();
            chk("stream_b0_dout", b_dout0, 32'(i * 3));
            chk("stream_b0_valid", 32'(b_valid0), 32'd1);
            if (i > 0) chk("stream_b1_dout", b_dout1, 32'((i - 1) * 3));
        end
        idle();
        step();
        chk("hold_b0_dout", b_dout0, 32'd45);
        chk("hold_b0_valid", 32'(b_valid0), 32'd0);
        chk("tail_b1_dout", b_dout1, 32'd45);
        chk("tail_b1_valid", 32'(b_valid1), 32'd1);
        step();
        chk("hold_b1_dout", b_dout1, 32'd45);
        chk("hold_b1_valid", 32'(b_valid1), 32'd0);

        // Out of range (only for the 1000-word instance)
        drive(1'b1, 4'hF, 32'hFF, 1000, 1'b0, 0);
        step();
        drive(1'b1, 4'h0, 32'h0, 999, 1'b1, 1000);
        step();
        chk("oor_b0_inrange", b_dout0, 32'hFF);
        chk("oor_a0_999", a_dout0, 32'hA5);
        idle();
        step();
        chk("oor_b1_dout", b_dout1, 32'h0);
        chk("oor_b1_valid", 32'(b_valid1), 32'd1);
        chk("oor_a1_999", a_dout1, 32'hA5);

        // Randomised traffic with frequent same-address collisions
        for (int i = 0; i < 300; i++) begin
            int aa;
            int ba;
            aa = pick_addr();
            ba = ($urandom_range(0, 3) == 0) ? aa : pick_addr();
            drive(1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom), aa,
                  1'($urandom_range(0, 1)), ba);
            step();
        end

        // Reset in the middle of a read on the registered-output instance
        drive(1'b0, 4'h0, 32'h0, 0, 1'b1, 3);
        step();
        idle();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_b1_valid", 32'(b_valid1), 32'd0);
        chk("rst_b0_dout", b_dout0, 32'h0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("post_rst_b1_valid", 32'(b_valid1), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bram_dp_param
`default_nettype wire
